// File: rtl/bist_ora_misr.sv
// bist_ora_misr: BIST output response analyzer.
// Compresses the CUT {carry,sum} responses into a MISR. Once the TPG reports
// complete, it compares the signature with GOLDEN and holds
// test_done/test_pass until reset.
// Optional feature macro: ORA_CNT_CHECK_EN. When it is defined, a saturating
// vector counter is added, the vec_count port is exposed, and the pass verdict
// also requires vec_count == EXP_CNT.

// One MISR bit: shifted-in neighbour, optional feedback tap, response bit.
module bist_ora_misr_cell #(
  parameter bit TAP      = 1'b0,
  parameter bit SEED_BIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic prev,
  input  logic fb,
  input  logic r,
  output logic q
);

  // Per-bit signature register; reset loads this bit's seed.
  always_ff @(posedge clock) begin
    if (!reset)  q <= SEED_BIT;
    else if (en) q <= prev ^ (TAP & fb) ^ r;
  end

endmodule

module bist_ora_misr #(
  parameter int                RESP_W  = 2,
  parameter int                MISR_W  = 3,
  parameter logic [MISR_W-1:0] POLY    = 3'b011,
  parameter logic [MISR_W-1:0] SEED    = 3'b000,
  parameter logic [MISR_W-1:0] GOLDEN  = 3'b000,
  parameter int                EXP_CNT = 7,
  parameter int                CNT_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              resp_valid,
  input  logic              tpg_complete,
  output logic [MISR_W-1:0] signature,
  output logic              test_done,
  output logic              test_pass
`ifdef ORA_CNT_CHECK_EN
  ,
  output logic [CNT_W-1:0]  vec_count
`endif
);

  // Parameter sanity: responses must fit in the signature, and the expected
  // count must lie within the counter's range.
  if (MISR_W < RESP_W) begin : g_bad_width
    $error("bist_ora_misr: MISR_W must be >= RESP_W");
  end
  if (EXP_CNT > (2**CNT_W) - 1) begin : g_bad_cnt
    $error("bist_ora_misr: EXP_CNT does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              compress;
  logic              cnt_ok;
  logic              done_q, pass_q;
  logic [MISR_W-1:0] sig;
  logic [MISR_W-1:0] resp_ext;
  logic              fb;

  assign resp_ext = MISR_W'(resp_in);
  assign fb       = sig[MISR_W-1];

  // Compression happens only while collecting, IDLE included, so that the
  // first vector is never lost.
  assign compress = resp_valid && ((state_q == IDLE) || (state_q == RUN));

  // MISR as an array of per-bit cells. Bit 0 always takes feedback; the
  // higher bits take feedback only where POLY has a tap.
  for (genvar i = 0; i < MISR_W; i++) begin : g_cell
    if (i == 0) begin : g_lsb
      bist_ora_misr_cell #(.TAP(1'b1), .SEED_BIT(SEED[0])) u_cell (
        .clock (clock),
        .reset (reset),
        .en    (compress),
        .prev  (1'b0),
        .fb    (fb),
        .r     (resp_ext[0]),
        .q     (sig[0])
      );
    end else begin : g_bit
      bist_ora_misr_cell #(.TAP(POLY[i]), .SEED_BIT(SEED[i])) u_cell (
        .clock (clock),
        .reset (reset),
        .en    (compress),
        .prev  (sig[i-1]),
        .fb    (fb),
        .r     (resp_ext[i]),
        .q     (sig[i])
      );
    end
  end

`ifdef ORA_CNT_CHECK_EN
  logic [CNT_W-1:0] cnt_q;

  // Count compressed vectors; saturate so that overruns cannot alias back
  // onto EXP_CNT.
  always_ff @(posedge clock) begin
    if (!reset)                      cnt_q <= '0;
    else if (compress && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_ok    = (cnt_q == CNT_W'(EXP_CNT));
  assign vec_count = cnt_q;
`else
  assign cnt_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state. A complete seen in IDLE or RUN wins over staying to collect;
  // that cycle's vector is still compressed through the compress enable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tpg_complete)    state_d = CHECK;
        else if (resp_valid) state_d = RUN;
      end
      RUN: begin
        if (tpg_complete) state_d = CHECK;
      end
      CHECK:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Verdict registers. They are written only in CHECK, so that pass stays 0
  // until done is set and both are frozen afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (state_q == CHECK) begin
      done_q <= 1'b1;
      pass_q <= (sig == GOLDEN) && cnt_ok;
    end
  end

  assign signature = sig;
  assign test_done = done_q;
  assign test_pass = pass_q;

endmodule

// File: tb/tb_bist_ora_misr.sv
// tb_bist_ora_misr: directed bench for bist_ora_misr.
// Three DUTs share the same stimulus. They differ only in GOLDEN (000, 011,
// 101). A polynomial-arithmetic reference model is compared against every
// DUT on every negedge. Hand-computed literals pin the model at key points.
// Build with ORA_CNT_CHECK_EN defined to exercise the vector counter.
module tb_bist_ora_misr;

  localparam int N = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] resp_in = 2'b00;
  logic       resp_valid = 1'b0;
  logic       tpg_complete = 1'b0;

  logic [N-1:0][2:0] sig_v;
  logic [N-1:0]      done_v;
  logic [N-1:0]      pass_v;
`ifdef ORA_CNT_CHECK_EN
  logic [N-1:0][3:0] cnt_v;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  bist_ora_misr #(.GOLDEN(3'b000)) u_a (
    .clock(clock), .reset(reset), .resp_in(resp_in), .resp_valid(resp_valid),
    .tpg_complete(tpg_complete), .signature(sig_v[0]), .test_done(done_v[0]),
    .test_pass(pass_v[0])
`ifdef ORA_CNT_CHECK_EN
    , .vec_count(cnt_v[0])
`endif
  );

  bist_ora_misr #(.GOLDEN(3'b011)) u_b (
    .clock(clock), .reset(reset), .resp_in(resp_in), .resp_valid(resp_valid),
    .tpg_complete(tpg_complete), .signature(sig_v[1]), .test_done(done_v[1]),
    .test_pass(pass_v[1])
`ifdef ORA_CNT_CHECK_EN
    , .vec_count(cnt_v[1])
`endif
  );

  bist_ora_misr #(.GOLDEN(3'b101)) u_c (
    .clock(clock), .reset(reset), .resp_in(resp_in), .resp_valid(resp_valid),
    .tpg_complete(tpg_complete), .signature(sig_v[2]), .test_done(done_v[2]),
    .test_pass(pass_v[2])
`ifdef ORA_CNT_CHECK_EN
    , .vec_count(cnt_v[2])
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [2:0] gold(input int i);
    case (i)
      0:       return 3'b000;
      1:       return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  // The signature is a polynomial over GF(2): multiply by x modulo
  // x^3 + x + 1, then add the response.
  function automatic logic [2:0] misr_step(input logic [2:0] s, input logic [1:0] r);
    int v;
    v = int'(s) * 2;
    if (v >= 8) v = v ^ 11;
    v = v ^ int'(r);
    return 3'(v);
  endfunction

  logic [2:0] m_sig    [N];
  bit         m_done   [N];
  bit         m_pass   [N];
  bit         m_closed [N];
  int         m_cnt    [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_sig[i] = 3'b000; m_done[i] = 0; m_pass[i] = 0; m_closed[i] = 0; m_cnt[i] = 0;
    end
  end

  // Model update at each edge: collect until complete; the next edge
  // delivers the verdict; then hold everything.
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_sig[i] = 3'b000; m_done[i] = 0; m_pass[i] = 0; m_closed[i] = 0; m_cnt[i] = 0;
      end else if (!m_done[i]) begin
        if (!m_closed[i]) begin
          if (resp_valid) begin
            m_sig[i] = misr_step(m_sig[i], resp_in);
            if (m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
          end
          if (tpg_complete) m_closed[i] = 1;
        end else begin
          m_done[i] = 1;
`ifdef ORA_CNT_CHECK_EN
          m_pass[i] = (m_sig[i] == gold(i)) && (m_cnt[i] == 7);
`else
          m_pass[i] = (m_sig[i] == gold(i));
`endif
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every DUT against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_sig[%0d]", i), int'(sig_v[i]), int'(m_sig[i]));
        check($sformatf("model_done[%0d]", i), int'(done_v[i]), int'(m_done[i]));
        check($sformatf("model_pass[%0d]", i), int'(pass_v[i]), int'(m_pass[i]));
`ifdef ORA_CNT_CHECK_EN
        check($sformatf("model_cnt[%0d]", i), int'(cnt_v[i]), m_cnt[i]);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [1:0] r, input bit c);
    resp_valid = v; resp_in = r; tpg_complete = c;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 2'b00, 0);
    cyc(0, 2'b00, 0);
    reset = 1'b1;
  endtask

  // Expected verdicts that depend on whether the counter gate is built in.
`ifdef ORA_CNT_CHECK_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  initial begin
    logic [1:0] seq7 [7];
    logic [1:0] seq6 [6];
    seq7 = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    seq6 = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};

    // Power-on reset.
    reset = 1'b0;
    cyc(0, 2'b00, 0);
    cmp_en = 1'b1;
    cyc(0, 2'b00, 0);
    check("reset_sig", int'(sig_v[0]), 0);
    check("reset_done", int'(done_v[0]), 0);
    check("reset_pass", int'(pass_v[0]), 0);
    reset = 1'b1;

    // 1: reset mid-run; it overrides valid and complete.
    cyc(1, 2'b01, 0);
    cyc(1, 2'b00, 0);
    check("midrun_sig", int'(sig_v[0]), 3'b010);
    reset = 1'b0;
    cyc(1, 2'b11, 1);
    cyc(1, 2'b11, 1);
    check("midrun_rst_sig", int'(sig_v[0]), 0);
    check("midrun_rst_done", int'(done_v[0]), 0);
    check("midrun_rst_pass", int'(pass_v[0]), 0);
    reset = 1'b1;
    cyc(0, 2'b00, 0);
    check("after_rst_idle_done", int'(done_v[0]), 0);

    // 2/3: vectors 01,00,00,00, then complete.
    cyc(1, 2'b01, 0); check("s2_sig1", int'(sig_v[0]), 3'b001);
    cyc(1, 2'b00, 0); check("s2_sig2", int'(sig_v[0]), 3'b010);
    cyc(1, 2'b00, 0); check("s2_sig3", int'(sig_v[0]), 3'b100);
    cyc(1, 2'b00, 0); check("s2_sig4", int'(sig_v[0]), 3'b011);
    cyc(0, 2'b00, 1); check("s2_done_k", int'(done_v[0]), 0);
    cyc(0, 2'b00, 0);
    check("s2_done_k1", int'(done_v[0]), 1);
    check("s2_pass_a", int'(pass_v[0]), 0);
    check("s3_done_b", int'(done_v[1]), 1);
    check("s3_pass_b", int'(pass_v[1]), CNT ? 0 : 1);
    for (int k = 0; k < 5; k++) cyc(1, 2'b11, 0);
    check("s3_frozen_sig", int'(sig_v[1]), 3'b011);
    check("s3_frozen_pass", int'(pass_v[1]), CNT ? 0 : 1);

    // 4: valid vector on the same cycle that complete rises.
    do_reset();
    cyc(1, 2'b11, 1);
    check("s4_sig", int'(sig_v[1]), 3'b011);
    check("s4_done_k", int'(done_v[1]), 0);
    cyc(0, 2'b00, 0);
    check("s4_done", int'(done_v[1]), 1);
    check("s4_pass", int'(pass_v[1]), CNT ? 0 : 1);

    // 5: complete with no vectors; complete is held high afterwards.
    do_reset();
    cyc(0, 2'b00, 1);
    check("s5_done_k", int'(done_v[0]), 0);
    cyc(0, 2'b00, 1);
    check("s5_done", int'(done_v[0]), 1);
    check("s5_pass", int'(pass_v[0]), CNT ? 0 : 1);
    for (int k = 0; k < 3; k++) cyc(1, 2'b01, 1);
    check("s5_hold_sig", int'(sig_v[0]), 0);
    check("s5_hold_pass", int'(pass_v[0]), CNT ? 0 : 1);

    // 6a: seven vectors, reaching signature 101.
    do_reset();
    for (int k = 0; k < 7; k++) cyc(1, seq7[k], 0);
    check("s6a_sig", int'(sig_v[2]), 3'b101);
`ifdef ORA_CNT_CHECK_EN
    check("s6a_cnt", int'(cnt_v[2]), 7);
`endif
    cyc(0, 2'b00, 1);
    cyc(0, 2'b00, 0);
    check("s6a_pass", int'(pass_v[2]), 1);

    // 6b: six vectors that reach the same signature.
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1, seq6[k], 0);
    check("s6b_sig", int'(sig_v[2]), 3'b101);
    cyc(0, 2'b00, 1);
    cyc(0, 2'b00, 0);
    check("s6b_pass", int'(pass_v[2]), CNT ? 0 : 1);

    // 6c: twenty vectors; the counter saturates.
    do_reset();
    for (int k = 0; k < 20; k++) cyc(1, 2'b01, 0);
`ifdef ORA_CNT_CHECK_EN
    check("s6c_cnt_sat", int'(cnt_v[0]), 15);
`endif
    cyc(0, 2'b00, 1);
    cyc(0, 2'b00, 0);
    check("s6c_done", int'(done_v[0]), 1);
    cyc(0, 2'b00, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
